// File: rtl/riscv_data_bus_ctrl.sv
// Data-side bus controller: decodes core/loader accesses to data memory or I/O and arbitrates the shared port.
// Optional macro BUS_FAULT_CNT_EN adds fault_count/fault_addr outputs for unmapped-access tracking.
module riscv_data_bus_ctrl #(
    parameter logic [31:0] DATA_START_ADDRESS = 32'h0000_2000,
    parameter logic [31:0] DATA_SIZE_BYTES    = 32'h0000_2000,
    parameter logic [31:0] IO_START_ADDRESS   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    input  logic        proc_memread,
    input  logic        proc_memwrite,
    output logic [31:0] proc_rdata,
    output logic        proc_stall,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        ld_we,
    output logic        ld_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] io_addr,
    output logic        io_read,
    output logic        io_write,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_valid,
    output logic        bus_err
`ifdef BUS_FAULT_CNT_EN
    ,
    output logic [15:0] fault_count,
    output logic [31:0] fault_addr
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_LDR} state_t;
    // RG_NONE doubles as the unmapped decode result and the "no read pending" select.
    typedef enum logic [1:0] {RG_NONE, RG_MEM, RG_IO} region_t;

    state_t      state, state_nxt;
    region_t     region, rd_sel;
    logic [31:0] bus_addr, bus_wdata, mem_offset;
    logic        cpu_wr, cpu_rd, ldr_wr, any_wr, err_now;

    assign proc_stall = (state == ST_LDR) || ld_gnt;

    assign bus_addr   = ld_gnt ? ld_addr  : proc_addr;
    assign bus_wdata  = ld_gnt ? ld_wdata : proc_wdata;
    assign mem_offset = bus_addr - DATA_START_ADDRESS;

    always_comb begin
        region = RG_NONE;
        if (mem_offset < DATA_SIZE_BYTES)
            region = RG_MEM;
        else if (bus_addr[31:16] == IO_START_ADDRESS[31:16])
            region = RG_IO;
    end

    // Stalled core strobes and everything during reset are masked here, before any side effect.
    assign cpu_wr  = rst && !proc_stall && proc_memwrite;
    assign cpu_rd  = rst && !proc_stall && proc_memread && !proc_memwrite;
    assign ldr_wr  = rst && ld_gnt && ld_we;
    assign any_wr  = cpu_wr || ldr_wr;
    assign err_now = (any_wr || cpu_rd) && (region == RG_NONE);

    assign mem_addr  = bus_addr;
    assign mem_wdata = bus_wdata;
    assign mem_we    = any_wr && (region == RG_MEM);
    assign io_addr   = bus_addr;
    assign io_wdata  = bus_wdata;
    assign io_write  = any_wr && (region == RG_IO);
    assign io_read   = cpu_rd && (region == RG_IO);

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (proc_memread || proc_memwrite)
                    state_nxt = ST_CPU;
                else if (ld_req)
                    state_nxt = ST_LDR;
            end
            ST_CPU:  state_nxt = ST_IDLE;
            ST_LDR:  if (!ld_req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ld_gnt  <= 1'b0;
            bus_err <= 1'b0;
            rd_sel  <= RG_NONE;
        end else begin
            state   <= state_nxt;
            ld_gnt  <= (state == ST_LDR) && ld_req;
            bus_err <= err_now;
            if (cpu_rd)
                rd_sel <= region;
        end
    end

    always_comb begin
        proc_rdata = 32'h0;
        unique case (rd_sel)
            RG_MEM:  proc_rdata = mem_rdata;
            RG_IO:   proc_rdata = io_valid ? io_rdata : 32'h0;
            default: proc_rdata = 32'h0;
        endcase
    end

`ifdef BUS_FAULT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_count <= 16'h0;
            fault_addr  <= 32'h0;
        end else if (err_now) begin
            if (fault_count != 16'hFFFF)
                fault_count <= fault_count + 16'd1;
            fault_addr <= bus_addr;
        end
    end
`endif

endmodule
